// File: rtl/hex_uart_tx.sv
// hex_uart_tx
// Streams the 32-bit hex entry value as ASCII characters to a byte-wide UART
// transmitter. Digits go out most-significant nibble first. Leading zero
// nibbles can be suppressed with the same rule the display uses for blanking,
// and the frame can optionally end with CR LF.
//
// Ports
//   clk      system clock
//   reset    asynchronous, active-high reset; aborts any frame in progress
//   start    one-cycle request to send value (ignored while busy or in DONE)
//   value    32-bit value to send, nibble [31:28] first
//   txready  transmitter can accept a byte when high
//   txdata   ASCII byte presented to the transmitter
//   txclk    one-cycle load strobe to the transmitter
//   busy     high from the cycle after an accepted start until done
//   done     one-cycle pulse after the last byte handshake completes
//
// Byte handshake (one character):
//   WAITRDY waits for txready=1 and registers txdata. PULSE registers
//   txclk=1, so txclk is high during the first HOLD cycle only, one cycle
//   after txdata settled. HOLD waits for txready=0 (byte taken). ACKWAIT waits
//   for txready=1 before advancing to the next character or finishing.
//   Each state is exactly one cycle when the transmitter responds at once.

module hex_uart_tx #(
   parameter bit SUPPRESS = 1'b1,  // 1: skip leading zero nibbles
   parameter bit EOL      = 1'b1,  // 1: append CR LF after the digits
   parameter bit UPPER    = 1'b1   // 1: 'A'-'F', 0: 'a'-'f'
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] value,
   input  logic        txready,
   output logic [7:0]  txdata,
   output logic        txclk,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAITRDY = 3'd1,
      PULSE   = 3'd2,
      HOLD    = 3'd3,
      ACKWAIT = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Which part of the frame the current character belongs to.
   typedef enum logic [1:0] {
      PH_DIGIT = 2'd0,
      PH_CR    = 2'd1,
      PH_LF    = 2'd2
   } phase_t;

   state_t      state;
   phase_t      phase;
   logic [31:0] shadow;     // value captured at the accepted start
   logic [2:0]  idx;        // nibble index of the current digit

   logic [2:0]  first_idx;
   logic [3:0]  cur_nib;
   logic [7:0]  cur_char;
   logic        last_char;

   // Nibble to ASCII hex character.
   function automatic logic [7:0] to_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (UPPER)
         return 8'h41 + {4'h0, n} - 8'd10;
      else
         return 8'h61 + {4'h0, n} - 8'd10;
   endfunction

   // Starting digit. With suppression this is the highest nonzero nibble;
   // the ascending loop lets the highest match win. An all-zero value falls
   // through to index 0 so a single '0' is still sent.
   always_comb begin
      first_idx = 3'd0;
      if (!SUPPRESS) begin
         first_idx = 3'd7;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (value[4*i +: 4] != 4'h0)
               first_idx = 3'(i);
         end
      end
   end

   assign cur_nib = shadow[{idx, 2'b00} +: 4];

   always_comb begin
      case (phase)
         PH_CR:   cur_char = 8'h0D;
         PH_LF:   cur_char = 8'h0A;
         default: cur_char = to_ascii(cur_nib);
      endcase
   end

   // The character just handshaken is the final one of the frame.
   always_comb begin
      last_char = 1'b0;
      case (phase)
         PH_DIGIT: last_char = (idx == 3'd0) && !EOL;
         PH_LF:    last_char = 1'b1;
         default:  last_char = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         phase  <= PH_DIGIT;
         shadow <= 32'h0;
         idx    <= 3'd0;
         txdata <= 8'h00;
         txclk  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shadow <= value;
                  idx    <= first_idx;
                  phase  <= PH_DIGIT;
                  busy   <= 1'b1;
                  state  <= WAITRDY;
               end
            end

            WAITRDY: begin
               if (txready) begin
                  txdata <= cur_char;
                  state  <= PULSE;
               end
            end

            // txdata has been stable for this whole cycle; raise the strobe.
            PULSE: begin
               txclk <= 1'b1;
               state <= HOLD;
            end

            // Strobe drops after one cycle no matter how long txready stays
            // high, so a slow transmitter never sees a second load.
            HOLD: begin
               txclk <= 1'b0;
               if (!txready)
                  state <= ACKWAIT;
            end

            ACKWAIT: begin
               if (txready) begin
                  if (last_char) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     txdata <= 8'h00;
                  end else begin
                     state <= WAITRDY;
                     if (phase == PH_DIGIT) begin
                        if (idx != 3'd0)
                           idx <= idx - 3'd1;
                        else
                           phase <= PH_CR;
                     end else begin
                        phase <= PH_LF;
                     end
                  end
               end
            end

            // start is deliberately not sampled here.
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_uart_tx.sv
// Testbench for hex_uart_tx.
// dut_a: SUPPRESS=1, EOL=1, UPPER=1 with a transmitter that drops txready two
// cycles after each load strobe and raises it again two cycles later.
// dut_b: SUPPRESS=0, EOL=0, UPPER=0 with a transmitter that answers at once,
// so every byte takes the minimum four cycles.
`timescale 1ns/1ps

module tb_hex_uart_tx;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests_run    = 0;
   int tests_failed = 0;

   // ---------------- DUT A ----------------
   logic        a_start = 1'b0;
   logic [31:0] a_value = 32'h0;
   logic        a_txready = 1'b1;
   logic [7:0]  a_txdata;
   logic        a_txclk, a_busy, a_done;

   hex_uart_tx #(.SUPPRESS(1'b1), .EOL(1'b1), .UPPER(1'b1)) dut_a (
      .clk(clk), .reset(rst), .start(a_start), .value(a_value),
      .txready(a_txready), .txdata(a_txdata), .txclk(a_txclk),
      .busy(a_busy), .done(a_done)
   );

   // ---------------- DUT B ----------------
   logic        b_start = 1'b0;
   logic [31:0] b_value = 32'h0;
   logic        b_txready = 1'b1;
   logic [7:0]  b_txdata;
   logic        b_txclk, b_busy, b_done;

   hex_uart_tx #(.SUPPRESS(1'b0), .EOL(1'b0), .UPPER(1'b0)) dut_b (
      .clk(clk), .reset(rst), .start(b_start), .value(b_value),
      .txready(b_txready), .txdata(b_txdata), .txclk(b_txclk),
      .busy(b_busy), .done(b_done)
   );

   // ---------------- monitors + transmitter models (negedge) ----------------
   logic [79:0] a_frame = '0, b_frame = '0;   // last 10 bytes, newest in [7:0]
   int a_nbytes = 0, b_nbytes = 0;
   int a_done_cnt = 0, b_done_cnt = 0;
   int a_dbl = 0, b_dbl = 0;                 // strobe high two cycles running
   int a_unstable = 0, b_unstable = 0;       // txdata changed as strobe rose
   int b_gap_bad = 0;                        // strobe spacing other than 4
   int b_last_ts = 0;
   logic       a_prev_clk = 1'b0, b_prev_clk = 1'b0;
   logic [7:0] a_prev_data = 8'h00, b_prev_data = 8'h00;

   logic a_rdy_int = 1'b1;
   logic a_stall = 1'b0;
   int   a_dly = 0, a_low = 0;

   always @(negedge clk) begin
      if (a_txclk === 1'b1) begin
         a_frame = {a_frame[71:0], a_txdata};
         a_nbytes++;
         if (a_prev_clk === 1'b1) a_dbl++;
         if (a_txdata !== a_prev_data) a_unstable++;
      end
      if (a_done === 1'b1) a_done_cnt++;
      a_prev_clk  = a_txclk;
      a_prev_data = a_txdata;
      // transmitter A: drop ready 2 cycles after a load, restore 2 later
      if (a_txclk === 1'b1) begin
         a_dly = 2;
      end else if (a_dly > 0) begin
         a_dly--;
         if (a_dly == 0) begin
            a_rdy_int = 1'b0;
            a_low = 2;
         end
      end else if (a_low > 0) begin
         a_low--;
         if (a_low == 0) a_rdy_int = 1'b1;
      end
      a_txready = a_rdy_int && !a_stall;
   end

   always @(negedge clk) begin
      if (b_txclk === 1'b1) begin
         b_frame = {b_frame[71:0], b_txdata};
         if (b_nbytes > 0 && (cyc - b_last_ts) != 4) b_gap_bad++;
         b_last_ts = cyc;
         b_nbytes++;
         if (b_prev_clk === 1'b1) b_dbl++;
         if (b_txdata !== b_prev_data) b_unstable++;
      end
      if (b_done === 1'b1) b_done_cnt++;
      b_prev_clk  = b_txclk;
      b_prev_data = b_txdata;
      // transmitter B: takes the byte in the strobe cycle, ready again next
      b_txready = !(b_txclk === 1'b1);
   end

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic clear_mon();
      a_frame = '0; b_frame = '0;
      a_nbytes = 0; b_nbytes = 0;
      a_done_cnt = 0; b_done_cnt = 0;
      b_gap_bad = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic start_a(input logic [31:0] v);
      a_value = v;
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
   endtask

   task automatic start_b(input logic [31:0] v);
      b_value = v;
      b_start = 1'b1;
      @(posedge clk); #1;
      b_start = 1'b0;
   endtask

   // Returns in the cycle where done is high.
   task automatic wait_done_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (a_done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (b_done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_bytes_a(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (a_nbytes >= n) begin ok = 1'b1; break; end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_cycles(3);
      tests_run++;
      if ({a_txdata, a_txclk, a_busy, a_done} !== 11'h0) begin
         tests_failed++;
         $display("FAIL reset_a: got %h expected 0", {a_txdata, a_txclk, a_busy, a_done});
      end
      tests_run++;
      if ({b_txdata, b_txclk, b_busy, b_done} !== 11'h0) begin
         tests_failed++;
         $display("FAIL reset_b: got %h expected 0", {b_txdata, b_txclk, b_busy, b_done});
      end
      rst = 1'b0;
      idle_cycles(2);
   endtask

   task automatic test_a5();
      bit ok;
      clear_mon();
      start_a(32'h000000A5);
      tests_run++;
      if (a_busy !== 1'b1) begin
         tests_failed++; $display("FAIL a5_busy_rise: got %b expected 1", a_busy);
      end
      wait_done_a(ok);
      tests_run++;
      if (a_busy !== 1'b0) begin
         tests_failed++; $display("FAIL a5_busy_at_done: got %b expected 0", a_busy);
      end
      idle_cycles(3);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL a5_timeout: done got 0 expected 1"); end
      tests_run++;
      if (a_frame !== 80'h41350D0A || a_nbytes != 4) begin
         tests_failed++;
         $display("FAIL a5_frame: got %h/%0d expected %h/4", a_frame, a_nbytes, 80'h41350D0A);
      end
      tests_run++;
      if (a_done_cnt != 1) begin
         tests_failed++; $display("FAIL a5_done_count: got %0d expected 1", a_done_cnt);
      end
      tests_run++;
      if (a_busy !== 1'b0 || a_txdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL a5_idle_after: got busy=%b data=%h expected 0/00", a_busy, a_txdata);
      end
   endtask

   task automatic test_zero_and_full();
      bit ok;
      clear_mon();
      start_a(32'h00000000);
      wait_done_a(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || a_frame !== 80'h300D0A || a_nbytes != 3) begin
         tests_failed++;
         $display("FAIL zero_frame: got %h/%0d ok=%b expected %h/3", a_frame, a_nbytes, ok, 80'h300D0A);
      end
      clear_mon();
      start_a(32'h12345678);
      wait_done_a(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || a_frame !== 80'h31323334353637380D0A || a_nbytes != 10) begin
         tests_failed++;
         $display("FAIL full_frame: got %h/%0d ok=%b expected %h/10",
                  a_frame, a_nbytes, ok, 80'h31323334353637380D0A);
      end
   endtask

   task automatic test_no_suppress();
      bit ok;
      clear_mon();
      start_b(32'h0000BEEF);
      wait_done_b(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || b_frame !== 80'h3030303062656566 || b_nbytes != 8) begin
         tests_failed++;
         $display("FAIL beef_frame: got %h/%0d ok=%b expected %h/8",
                  b_frame, b_nbytes, ok, 80'h3030303062656566);
      end
      tests_run++;
      if (b_gap_bad != 0) begin
         tests_failed++; $display("FAIL beef_latency: got %0d bad gaps expected 0", b_gap_bad);
      end
      tests_run++;
      if (b_done_cnt != 1 || b_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL beef_done: got cnt=%0d busy=%b expected 1/0", b_done_cnt, b_busy);
      end
      clear_mon();
      start_b(32'h00000000);
      wait_done_b(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || b_frame !== 80'h3030303030303030 || b_nbytes != 8) begin
         tests_failed++;
         $display("FAIL b_zero_frame: got %h/%0d ok=%b expected %h/8",
                  b_frame, b_nbytes, ok, 80'h3030303030303030);
      end
   endtask

   task automatic test_stall();
      bit ok;
      logic [7:0] held;
      int clk_bad, data_bad;
      clear_mon();
      clk_bad = 0; data_bad = 0;
      start_a(32'h00C0FFEE);
      wait_bytes_a(1, ok);
      a_stall = 1'b1;
      held = a_txdata;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (a_txclk !== 1'b0) clk_bad++;
         if (a_txdata !== held) data_bad++;
      end
      tests_run++;
      if (!ok || held !== 8'h43) begin
         tests_failed++; $display("FAIL stall_first: got %h ok=%b expected 43", held, ok);
      end
      tests_run++;
      if (clk_bad != 0 || a_nbytes != 1) begin
         tests_failed++;
         $display("FAIL stall_txclk: got %0d pulses/%0d bytes expected 0/1", clk_bad, a_nbytes);
      end
      tests_run++;
      if (data_bad != 0) begin
         tests_failed++; $display("FAIL stall_txdata: got %0d changes expected 0", data_bad);
      end
      a_stall = 1'b0;
      wait_done_a(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || a_frame !== 80'h4330464645450D0A || a_nbytes != 8) begin
         tests_failed++;
         $display("FAIL stall_frame: got %h/%0d ok=%b expected %h/8",
                  a_frame, a_nbytes, ok, 80'h4330464645450D0A);
      end
   endtask

   task automatic test_restart_ignored();
      bit ok, ok2;
      clear_mon();
      start_a(32'h0000BEE5);
      wait_bytes_a(2, ok);
      start_a(32'hFFFFFFFF);   // value stays changed for the rest of the frame
      wait_done_a(ok2);
      idle_cycles(4);
      tests_run++;
      if (!ok || !ok2 || a_frame !== 80'h424545350D0A || a_nbytes != 6) begin
         tests_failed++;
         $display("FAIL restart_frame: got %h/%0d expected %h/6", a_frame, a_nbytes, 80'h424545350D0A);
      end
      tests_run++;
      if (a_done_cnt != 1 || a_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_done: got cnt=%0d busy=%b expected 1/0", a_done_cnt, a_busy);
      end
      a_value = 32'h0;
   endtask

   task automatic test_reset_mid();
      bit ok, found;
      clear_mon();
      start_a(32'h12345678);
      wait_bytes_a(2, ok);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (a_txdata === 8'h33 && a_txclk === 1'b0) begin found = 1'b1; break; end
         @(posedge clk); #1;
      end
      tests_run++;
      if (!ok || !found) begin
         tests_failed++; $display("FAIL rstmid_reach: got ok=%b found=%b expected 1/1", ok, found);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if ({a_txdata, a_txclk, a_busy, a_done} !== 11'h0) begin
         tests_failed++;
         $display("FAIL rstmid_async: got %h expected 0", {a_txdata, a_txclk, a_busy, a_done});
      end
      idle_cycles(3);
      tests_run++;
      if (a_nbytes != 2) begin
         tests_failed++; $display("FAIL rstmid_no_third: got %0d bytes expected 2", a_nbytes);
      end
      rst = 1'b0;
      idle_cycles(2);
      clear_mon();
      start_a(32'h000000A5);
      wait_done_a(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || a_frame !== 80'h41350D0A || a_nbytes != 4 || a_done_cnt != 1) begin
         tests_failed++;
         $display("FAIL rstmid_fresh: got %h/%0d done=%0d expected %h/4/1",
                  a_frame, a_nbytes, a_done_cnt, 80'h41350D0A);
      end
   endtask

   task automatic test_done_start();
      bit ok;
      clear_mon();
      start_a(32'h00000007);
      wait_done_a(ok);
      a_value = 32'h00000009;   // start during the DONE cycle
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      idle_cycles(20);
      tests_run++;
      if (!ok || a_busy !== 1'b0 || a_nbytes != 3 || a_frame !== 80'h370D0A) begin
         tests_failed++;
         $display("FAIL done_start_ignored: got busy=%b %h/%0d expected 0 %h/3",
                  a_busy, a_frame, a_nbytes, 80'h370D0A);
      end
      start_a(32'h00000002);
      wait_done_a(ok);
      @(posedge clk); #1;       // first IDLE cycle after DONE
      clear_mon();
      start_a(32'h00000003);
      tests_run++;
      if (a_busy !== 1'b1) begin
         tests_failed++; $display("FAIL idle_start_busy: got %b expected 1", a_busy);
      end
      wait_done_a(ok);
      idle_cycles(2);
      tests_run++;
      if (!ok || a_frame !== 80'h330D0A || a_nbytes != 3) begin
         tests_failed++;
         $display("FAIL idle_start_frame: got %h/%0d expected %h/3", a_frame, a_nbytes, 80'h330D0A);
      end
   endtask

   task automatic test_integrity();
      tests_run++;
      if (a_dbl != 0 || b_dbl != 0) begin
         tests_failed++; $display("FAIL double_pulse: got %0d/%0d expected 0/0", a_dbl, b_dbl);
      end
      tests_run++;
      if (a_unstable != 0 || b_unstable != 0) begin
         tests_failed++;
         $display("FAIL data_setup: got %0d/%0d late changes expected 0/0", a_unstable, b_unstable);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_a5();
      test_zero_and_full();
      test_no_suppress();
      test_stall();
      test_restart_ignored();
      test_reset_mid();
      test_done_start();
      test_integrity();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hex_uart_tx.md
Name: hex_uart_tx

Overview:
- Reads the 32-bit hex entry value, the same value shown on the seven-segment digits, and streams it as ASCII characters out of the top-level UART transmit port (txdata/txclk/txready).
- Emits the hex digits most-significant first, optionally followed by CR LF.
- Performs leading-zero suppression that matches the display's blanking rule.
- Triggered by a one-cycle start pulse, for example from the keypad strobe path.

Parameters:
- SUPPRESS, 1: 1 = skip leading zero nibbles (value 0 still sends a single '0'); 0 = always send 8 digits.
- EOL, 1: 1 = append 0x0D then 0x0A after the digits; 0 = digits only.
- UPPER, 1: 1 = hex letters are 0x41-0x46 ('A'-'F'); 0 = 0x61-0x66 ('a'-'f').

Ports:
- clk  input  1  system clock (hz100 at top).
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to send value.
- value  input  32  hex value to send, nibble [31:28] first.
- txready  input  1  UART transmitter can accept a byte when high.
- txdata  output  8  ASCII byte to the UART.
- txclk  output  1  load strobe to the UART, one cycle wide.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last byte handshake completes.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: state IDLE; txdata=0, txclk=0, busy=0, done=0; internal shadow register and nibble index = 0.
- Reset asserted mid-frame aborts immediately; the partial frame is not resumed.
- IDLE: on start=1, latch value into a shadow register, compute the first nibble index, go to WAITRDY, busy=1 next cycle.
  - Later changes to value are ignored until the next accepted start.
- start while busy=1 is ignored (not queued).
- First index, SUPPRESS=1: the highest nonzero nibble; if value==0, index 0 (single '0'). SUPPRESS=0: index 7 always.
- Character sequence: digits from first index down to 0, then 0x0D, 0x0A when EOL=1.
- ASCII mapping: nibble 0-9 -> 0x30+n; 10-15 -> 0x41+(n-10) (UPPER=1) or 0x61+(n-10) (UPPER=0).
- WAITRDY: wait for txready=1; drive txdata with the current character, go to PULSE. txdata is stable at least one cycle before txclk rises.
- PULSE: txclk=1 for exactly one cycle, then HOLD.
- HOLD: txclk=0, txdata held; wait for txready=0 (transmitter took the byte), then ACKWAIT.
- ACKWAIT:
  - On txready=1, advance to the next character and go to WAITRDY.
  - If no characters remain, go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, txdata returns to 0, go to IDLE. A start in the DONE cycle is ignored.
- Stalls: txready held low in WAITRDY, or held high in HOLD, stalls indefinitely with no timeout. txclk must never pulse twice for one character.
- Frame length: SUPPRESS=1 gives 1 to 8 digits plus EOL bytes; max 10 bytes per frame.
- Per-byte minimum latency with an instantly responding transmitter: WAITRDY 1 + PULSE 1 + HOLD 1 + ACKWAIT 1 = 4 cycles.

Test Plan:
- SUPPRESS=1, EOL=1, value=0x000000A5, transmitter model drops txready 2 cycles after each txclk -> bytes 0x41,0x35,0x0D,0x0A, each with exactly one txclk pulse; done pulses once; busy low afterwards.
- value=0x00000000 -> bytes 0x30,0x0D,0x0A. value=0x12345678 -> 0x31..0x38,0x0D,0x0A (10 bytes).
- SUPPRESS=0, EOL=0, UPPER=0, value=0x0000BEEF -> 0x30,0x30,0x30,0x30,0x62,0x65,0x65,0x66; no CR/LF.
- Handshake and input isolation:
  - Hold txready=0 for 50 cycles before the second byte -> txclk stays 0 and txdata stable throughout.
  - A second start mid-frame with a different value -> ignored; frame content unchanged.
- Assert reset during PULSE of byte 3 -> txclk, txdata, busy, done all 0 asynchronously; after release, a new start sends a complete fresh frame.
- start asserted in the DONE cycle -> ignored, no new frame; start one cycle later -> new frame begins.
